cordic_scheduler: RTL and testbench
===================================

# cordic_scheduler

Sequencer and arbiter that shares the single CORDIC rotation core between two requesters, such as the Fourier sin and cos channels. It accepts full-circle angles, folds each one into the first quadrant, and drives the core's initialize/calculate pulse pair. It then waits for the core's done pulse, applies the quadrant sign and swap correction, and returns the result to the requester that was granted. Only one transaction is outstanding at a time.

## Interface
- `TO_CYCLES`, default 64: number of WAIT cycles without `core_done` before the scheduler aborts the transaction with an error.
- `clk` in 1: the single clock; all logic is on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req_valid` in 2: request valid, bit r belongs to requester r.
- `req_ready` out 2: request accepted, one-hot or zero.
- `req_theta0` in 16: requester 0 angle, unsigned Q3.13 radians.
- `req_theta1` in 16: requester 1 angle, unsigned Q3.13 radians.
- `req_mode` in 2: per requester, 0 = cos, 1 = sin.
- `rsp_valid` out 2: response valid for the granted requester.
- `rsp_ready` in 2: response accepted.
- `rsp_result` out 16: signed Q2.14 result, shared by both requesters.
- `rsp_err` out 1: the response is a timeout abort.
- `core_theta` out 16: folded angle, Q2.14 radians, in [0, π/2).
- `core_mode` out 1: trig mode sent to the core.
- `core_init` out 1: one-cycle initialize pulse to the core.
- `core_calc` out 1: one-cycle calculate pulse to the core.
- `core_done` in 1: one-cycle pulse from the core; `core_result` is valid in the same cycle.
- `core_result` in 16: signed Q2.14 core output.

## Operation
- **Constants (Q3.13):**
  - HALF_PI = 12868
  - PI = 25736
  - THREE_HALF_PI = 38604
  - TWO_PI = 51472
- **FSM states:** IDLE, FOLD, INIT, CALC, WAIT, FIX, RESP.
- **IDLE:**
  - Arbitration is round-robin. The priority pointer names the preferred requester; reset sets it to 0.
  - `req_ready[g]` is asserted combinationally for the winner g only.
  - On the handshake, the scheduler latches θ, mode and g, then goes to FOLD.
  - The pointer moves to the other requester when the transaction completes in RESP.
- **FOLD (one cycle):**
  - If θ ≥ TWO_PI, subtract TWO_PI once to get θ'.
  - Quadrant q = number of constants among HALF_PI, PI and THREE_HALF_PI that are ≤ θ'.
  - Residual r = θ' − q·HALF_PI, computed by constant-select subtract with no multiplier.
  - `core_theta` = r << 1, which converts Q3.13 to Q2.14.
  - `core_mode` = mode XOR q[0].
  - Negate flag:
    - cos: set when q = 1 or 2.
    - sin: set when q = 2 or 3.
- **INIT:** `core_init` = 1 for one cycle.
- **CALC:** `core_calc` = 1 for one cycle; the timeout counter is cleared.
- **WAIT:**
  - When `core_done` = 1, latch `core_result`, clear the error flag, go to FIX.
  - When the counter reaches TO_CYCLES−1 with no done, latch result 0, set the error flag, go to RESP.
- **FIX:** if the negate flag is set, result = two's-complement negate (~x+1, 16 bits, wrapping). 0x8000 stays 0x8000.
- **RESP:**
  - `rsp_valid[g]` = 1 and holds until `rsp_ready[g]`.
  - `rsp_result` and `rsp_err` are stable while `rsp_valid` is high.
  - On the handshake: return to IDLE and update the pointer.
  - `rsp_ready` of the non-granted requester is ignored.
- **Ignored events:**
  - `core_done` outside WAIT is ignored.
  - Requests arriving outside IDLE are held off with `req_ready` = 0.

## Timing
- **Reset values:**
  - `req_ready` = 0, `rsp_valid` = 0, `rsp_result` = 0, `rsp_err` = 0.
  - `core_theta` = 0, `core_mode` = 0, `core_init` = 0, `core_calc` = 0.
  - State IDLE, pointer 0.
- **Reset mid-operation:**
  - The in-flight transaction is dropped and no response is produced.
  - No pulse fires in the reset cycle.
  - The core is not reset by the scheduler; the next `core_init` reinitializes it.
- **Cycle sequence** (cycle 0 is the request handshake edge):
  - Cycle 1: FOLD.
  - Cycle 2: `core_init`.
  - Cycle 3: `core_calc`.
  - WAIT begins in cycle 4.
  - If `core_done` arrives in cycle D, FIX is cycle D+1 and `rsp_valid` rises in cycle D+2.
- **Core timeout:** `rsp_valid` with `rsp_err` rises at cycle 4+TO_CYCLES.
- **Handshake timing:** a `rsp_ready` already high completes the handshake in the first RESP cycle. A new request can be accepted in the next cycle.
- **Simultaneous requests:** with both `req_valid` bits high, the pointer holder wins. Back-to-back contention alternates grants 0,1,0,1.
- `core_theta` and `core_mode` stay stable from FOLD through WAIT.

## Test plan
- **Sin at zero:** reset, requester 0: θ=0, sin. Core model returns 0x0000 at D=12.
  - Required: `core_theta`=0, `core_mode`=1.
  - Required: `rsp_valid[0]` at cycle 14, `rsp_result`=0x0000, `rsp_err`=0.
- **Cos at π:** θ=25736, cos. Core returns 0x4000.
  - Required: q=2, `core_theta`=0, `core_mode`=0.
  - Required: `rsp_result`=0xC000.
- **Sin past π/2:** θ=16964 (π/2+0.5), sin. Core returns 0x3829.
  - Required: `core_theta`=8192, `core_mode`=0 (swapped).
  - Required: result 0x3829, not negated.
- **Above 2π:** θ=60000, cos.
  - Required: θ'=8528, q=0, `core_theta`=17056.
  - Required: result passed through unchanged.
- **Contention:** both requesters hold `req_valid` for 4 transactions.
  - Required: grant order 0,1,0,1.
  - Required: `req_ready` is never two-hot.
  - Required: a response held 5 cycles by `rsp_ready`=0 keeps its result stable.
- **Timeout and reset:** core never pulses done.
  - Required: response at cycle 4+64 with `rsp_err`=1 and result 0.
  - Separately, assert `rst` during WAIT. Required: all outputs 0 the next cycle, no response, and a late `core_done` is ignored.

Source files
------------

// File: rtl/cordic_scheduler_if.sv
`default_nettype none
// ============================================================================
//  Module      : cordic_scheduler_if
//  Description : Request/response and CORDIC core signal bundle for the
//                shared-core scheduler. The slave side is the scheduler;
//                the master side is the environment that plays both
//                requesters and the rotation core.
//  Revision    : 1.0 - initial release
// ============================================================================
interface cordic_scheduler_if;
    // Requester side
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [15:0] req_theta0;
    logic [15:0] req_theta1;
    logic [1:0]  req_mode;
    logic [1:0]  rsp_valid;
    logic [1:0]  rsp_ready;
    logic [15:0] rsp_result;
    logic        rsp_err;
    // Rotation core side
    logic [15:0] core_theta;
    logic        core_mode;
    logic        core_init;
    logic        core_calc;
    logic        core_done;
    logic [15:0] core_result;

    modport master (
        output req_valid, req_theta0, req_theta1, req_mode, rsp_ready,
        output core_done, core_result,
        input  req_ready, rsp_valid, rsp_result, rsp_err,
        input  core_theta, core_mode, core_init, core_calc
    );

    modport slave (
        input  req_valid, req_theta0, req_theta1, req_mode, rsp_ready,
        input  core_done, core_result,
        output req_ready, rsp_valid, rsp_result, rsp_err,
        output core_theta, core_mode, core_init, core_calc
    );
endinterface
`default_nettype wire

// File: rtl/cordic_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : cordic_scheduler
//  Description : Round-robin sequencer sharing one CORDIC rotation core
//                between two requesters. Folds full-circle angles into the
//                first quadrant, pulses init/calc, waits for done (with a
//                timeout), applies the quadrant sign correction and returns
//                the result to the granted requester.
//  Revision    : 1.0 - initial release
// ============================================================================
module cordic_scheduler #(
    parameter int TO_CYCLES = 64
) (
    input  logic               clk,
    input  logic               rst,
    cordic_scheduler_if.slave  bus
);

    // Angle constants in Q3.13 radians
    localparam logic [15:0] C_HALF_PI       = 16'd12868;
    localparam logic [15:0] C_PI            = 16'd25736;
    localparam logic [15:0] C_THREE_HALF_PI = 16'd38604;
    localparam logic [15:0] C_TWO_PI        = 16'd51472;

    localparam int              CNT_W      = (TO_CYCLES > 1) ? $clog2(TO_CYCLES) : 1;
    localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(TO_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_FOLD = 3'd1,
        S_INIT = 3'd2,
        S_CALC = 3'd3,
        S_WAIT = 3'd4,
        S_FIX  = 3'd5,
        S_RESP = 3'd6
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic             r_ptr;
    logic             r_grant;
    logic [15:0]      r_theta;
    logic             r_mode;
    logic             r_neg;
    logic [CNT_W-1:0] r_cnt;
    logic [15:0]      r_result;
    logic             r_err;

    logic             w_win;
    logic             w_req_hit;
    logic [15:0]      w_theta_wrap;
    logic [1:0]       w_quad;
    logic [15:0]      w_resid;
    logic             w_neg;
    logic [1:0]       w_req_ready;
    logic [1:0]       w_rsp_valid;
    logic             w_core_init;
    logic             w_core_calc;

    // Round-robin: the pointer holder wins whenever it is requesting
    assign w_req_hit = |bus.req_valid;
    assign w_win     = bus.req_valid[r_ptr] ? r_ptr : ~r_ptr;

    // Quadrant fold of the latched angle; the single wrap is enough because
    // a 16-bit Q3.13 angle is always below 2*TWO_PI
    always_comb begin
        w_theta_wrap = (r_theta >= C_TWO_PI) ? (r_theta - C_TWO_PI) : r_theta;
        if (w_theta_wrap >= C_THREE_HALF_PI) begin
            w_quad  = 2'd3;
            w_resid = w_theta_wrap - C_THREE_HALF_PI;
        end else if (w_theta_wrap >= C_PI) begin
            w_quad  = 2'd2;
            w_resid = w_theta_wrap - C_PI;
        end else if (w_theta_wrap >= C_HALF_PI) begin
            w_quad  = 2'd1;
            w_resid = w_theta_wrap - C_HALF_PI;
        end else begin
            w_quad  = 2'd0;
            w_resid = w_theta_wrap;
        end
        // sin is negative in quadrants 2,3; cos in quadrants 1,2
        w_neg = r_mode ? w_quad[1] : (w_quad[1] ^ w_quad[0]);
    end

    // Core operands follow the latched request, so they hold from FOLD on
    assign bus.core_theta = w_resid << 1;
    assign bus.core_mode  = r_mode ^ w_quad[0];

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and strobe decode; strobes are gated so nothing fires in a reset cycle
    always_comb begin
        w_next      = r_state;
        w_req_ready = 2'b00;
        w_rsp_valid = 2'b00;
        w_core_init = 1'b0;
        w_core_calc = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_req_hit) begin
                    w_req_ready = w_win ? 2'b10 : 2'b01;
                    w_next      = S_FOLD;
                end
            end
            S_FOLD: w_next = S_INIT;
            S_INIT: begin
                w_core_init = 1'b1;
                w_next      = S_CALC;
            end
            S_CALC: begin
                w_core_calc = 1'b1;
                w_next      = S_WAIT;
            end
            S_WAIT: begin
                if (bus.core_done) begin
                    w_next = S_FIX;
                end else if (r_cnt == C_CNT_LAST) begin
                    w_next = S_RESP;
                end
            end
            S_FIX:  w_next = S_RESP;
            S_RESP: begin
                w_rsp_valid = r_grant ? 2'b10 : 2'b01;
                if (bus.rsp_ready[r_grant]) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
        if (rst) begin
            w_req_ready = 2'b00;
            w_rsp_valid = 2'b00;
            w_core_init = 1'b0;
            w_core_calc = 1'b0;
        end
    end

    assign bus.req_ready  = w_req_ready;
    assign bus.rsp_valid  = w_rsp_valid;
    assign bus.core_init  = w_core_init;
    assign bus.core_calc  = w_core_calc;
    assign bus.rsp_result = r_result;
    assign bus.rsp_err    = r_err;

    // Transaction datapath: request latch, sign flag, timeout, result, pointer
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr    <= 1'b0;
            r_grant  <= 1'b0;
            r_theta  <= 16'd0;
            r_mode   <= 1'b0;
            r_neg    <= 1'b0;
            r_cnt    <= '0;
            r_result <= 16'd0;
            r_err    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_req_hit) begin
                        r_grant <= w_win;
                        r_theta <= w_win ? bus.req_theta1 : bus.req_theta0;
                        r_mode  <= bus.req_mode[w_win];
                    end
                end
                S_FOLD: r_neg <= w_neg;
                S_CALC: r_cnt <= '0;
                S_WAIT: begin
                    if (bus.core_done) begin
                        r_result <= bus.core_result;
                        r_err    <= 1'b0;
                    end else if (r_cnt == C_CNT_LAST) begin
                        r_result <= 16'd0;
                        r_err    <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_FIX: begin
                    if (r_neg) begin
                        r_result <= ~r_result + 16'd1;
                    end
                end
                S_RESP: begin
                    if (bus.rsp_ready[r_grant]) begin
                        r_ptr <= ~r_grant;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cordic_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cordic_scheduler
//  Description : Self-checking bench for cordic_scheduler. Plays both
//                requesters and the rotation core; expected fold, sign and
//                timing come from an arithmetic reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cordic_scheduler;

    localparam int TO = 64;

    logic clk = 1'b0;
    logic rst;

    cordic_scheduler_if bus();

    cordic_scheduler #(.TO_CYCLES(TO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int         n_tests = 0;
    int         n_fail  = 0;
    bit         exp_ptr = 1'b0;
    logic [1:0] grant_log[$];

    task automatic chk_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: wrap once, quadrant by integer division, residual by modulo
    function automatic void ref_model(input logic [15:0] th, input logic md, input logic [15:0] cv,
                                      output logic [15:0] ct, output logic cm, output logic [15:0] res);
        int t;
        int q;
        int r;
        bit neg;
        t = int'(th);
        if (t >= 51472) t = t - 51472;
        q   = t / 12868;
        r   = t % 12868;
        ct  = 16'(r * 2);
        cm  = md ^ (q % 2 == 1);
        neg = md ? (q >= 2) : (q == 1 || q == 2);
        res = neg ? (16'h0000 - cv) : cv;
    endfunction

    task automatic run_txn(input logic [1:0] valids, input logic [15:0] th0, input logic [15:0] th1,
                           input logic [1:0] modes, input int dly, input logic [15:0] cval,
                           input bit tmo, input int hold, input string tag);
        bit          win;
        int          c;
        int          init_c;
        int          calc_c;
        int          n_init;
        int          n_calc;
        int          rr_bad;
        logic [15:0] ct;
        logic [15:0] res;
        logic        cm;
        logic [1:0]  g1h;
        init_c = 0; calc_c = 0; n_init = 0; n_calc = 0; rr_bad = 0;
        win = valids[exp_ptr] ? exp_ptr : ~exp_ptr;
        g1h = win ? 2'b10 : 2'b01;
        ref_model(win ? th1 : th0, modes[win], cval, ct, cm, res);
        if (tmo) res = 16'd0;

        bus.req_theta0 = th0;
        bus.req_theta1 = th1;
        bus.req_mode   = modes;
        bus.req_valid  = valids;
        bus.rsp_ready  = (hold == 0) ? g1h : ~g1h;
        #1;
        c = 0;
        while (bus.req_ready == 2'b00 && c < 20) begin
            step();
            c++;
        end
        chk_val({tag, "_grant"}, 64'(bus.req_ready), 64'(g1h));
        grant_log.push_back(bus.req_ready);
        step();
        if (valids != 2'b11) bus.req_valid = 2'b00;

        c = 1;
        while (c < 4 + TO + 20) begin
            if (bus.rsp_valid != 2'b00) break;
            if (bus.core_init) begin n_init++; init_c = c; end
            if (bus.core_calc) begin n_calc++; calc_c = c; end
            if (bus.req_ready != 2'b00) rr_bad++;
            if (c == 4) begin
                chk_val({tag, "_core_theta"}, 64'(bus.core_theta), 64'(ct));
                chk_val({tag, "_core_mode"}, 64'(bus.core_mode), 64'(cm));
            end
            bus.core_done   = (!tmo && c == dly);
            bus.core_result = (c == dly) ? cval : 16'($urandom);
            step();
            c++;
        end
        bus.core_done = 1'b0;

        chk_val({tag, "_rsp_cycle"}, 64'(c), tmo ? 64'(4 + TO) : 64'(dly + 2));
        chk_val({tag, "_rsp"}, {bus.rsp_valid, bus.rsp_err, bus.rsp_result}, {g1h, tmo, res});
        chk_val({tag, "_pulses"}, {n_init[15:0], init_c[15:0], n_calc[15:0], calc_c[15:0]},
                {16'd1, 16'd2, 16'd1, 16'd3});
        chk_val({tag, "_req_held_off"}, 64'(rr_bad), 64'd0);
        for (int h = 0; h < hold; h++) begin
            step();
            chk_val({tag, "_hold_stable"}, {bus.rsp_valid, bus.rsp_err, bus.rsp_result}, {g1h, tmo, res});
        end
        bus.rsp_ready = g1h;
        step();
        chk_val({tag, "_rsp_drop"}, 64'(bus.rsp_valid), 64'd0);
        bus.rsp_ready = 2'b00;
        exp_ptr = ~win;
    endtask

    logic [15:0] edge_th[10] = '{16'd0, 16'd12867, 16'd12868, 16'd25735, 16'd25736,
                                 16'd38603, 16'd38604, 16'd51471, 16'd51472, 16'd65535};

    // Global bound so the run always terminates
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Main stimulus sequence
    initial begin
        logic [15:0] ta;
        logic [15:0] tb;
        int          bad;
        bus.req_valid   = 2'b00;
        bus.req_theta0  = 16'd0;
        bus.req_theta1  = 16'd0;
        bus.req_mode    = 2'b00;
        bus.rsp_ready   = 2'b00;
        bus.core_done   = 1'b0;
        bus.core_result = 16'd0;
        rst = 1'b1;
        step(); step(); step();
        chk_val("reset_outputs",
                {bus.req_ready, bus.rsp_valid, bus.rsp_result, bus.rsp_err,
                 bus.core_theta, bus.core_mode, bus.core_init, bus.core_calc}, 64'd0);
        rst = 1'b0;
        step();
        exp_ptr = 1'b0;

        run_txn(2'b01, 16'd0,     16'd0,     2'b01, 12, 16'h0000, 1'b0, 0, "sin_zero");
        run_txn(2'b01, 16'd25736, 16'd0,     2'b00, 9,  16'h4000, 1'b0, 1, "cos_pi");
        run_txn(2'b10, 16'd0,     16'd16964, 2'b10, 6,  16'h3829, 1'b0, 0, "sin_q1");
        run_txn(2'b01, 16'd60000, 16'd0,     2'b00, 5,  16'h1234, 1'b0, 0, "above_2pi");
        run_txn(2'b10, 16'd0,     16'd38604, 2'b00, 7,  16'h8000, 1'b0, 0, "neg_8000");

        grant_log.delete();
        for (int k = 0; k < 4; k++) begin
            run_txn(2'b11, 16'($urandom), 16'($urandom), 2'($urandom), 4 + (k * 3), 16'($urandom),
                    1'b0, (k == 0) ? 5 : 0, "contention");
        end
        chk_val("contention_order", {grant_log[0], grant_log[1], grant_log[2], grant_log[3]},
                64'({2'b01, 2'b10, 2'b01, 2'b10}));

        run_txn(2'b01, 16'd20000, 16'd0, 2'b00, 0, 16'h5555, 1'b1, 2, "timeout");

        for (int k = 0; k < 16; k++) begin
            ta = ($urandom_range(0, 1) == 1) ? edge_th[$urandom_range(0, 9)] : 16'($urandom);
            tb = ($urandom_range(0, 1) == 1) ? edge_th[$urandom_range(0, 9)] : 16'($urandom);
            run_txn(2'($urandom_range(1, 3)), ta, tb, 2'($urandom), $urandom_range(4, 20),
                    16'($urandom), 1'b0, $urandom_range(0, 3), "random");
        end

        // Reset during WAIT: drop the transaction and ignore a late done
        bus.req_theta0 = 16'd30000;
        bus.req_mode   = 2'b01;
        bus.req_valid  = 2'b01;
        step();
        bus.req_valid  = 2'b00;
        step(); step(); step(); step();
        rst = 1'b1;
        step();
        chk_val("reset_mid_wait",
                {bus.req_ready, bus.rsp_valid, bus.rsp_result, bus.rsp_err,
                 bus.core_theta, bus.core_mode, bus.core_init, bus.core_calc}, 64'd0);
        rst = 1'b0;
        bus.core_done   = 1'b1;
        bus.core_result = 16'h7777;
        step();
        bus.core_done   = 1'b0;
        bad = 0;
        for (int k = 0; k < 10; k++) begin
            if (bus.rsp_valid != 2'b00 || bus.rsp_result != 16'd0) bad++;
            step();
        end
        chk_val("late_done_ignored", 64'(bad), 64'd0);
        exp_ptr = 1'b0;
        run_txn(2'b11, 16'd1000, 16'd2000, 2'b10, 8, 16'h2222, 1'b0, 0, "after_reset");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
